md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit.sv | 91 +++++++++
 tb/tb_md_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: request/result bundle between a pipeline and the multiply/divide unit.
interface md_unit_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flush;
  logic         hi_we;
  logic         lo_we;
  logic [N-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div0;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );
  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one bit per cycle.
module md_unit #(parameter int N = 32) (
  input logic    clk,
  input logic    rst_n,
  md_unit_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t         state, state_d;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   opd;
  logic [2*N-1:0] acc, acc_nx, prod;
  logic [N+1:0]   alu;
  logic [N:0]     rem_sh;
  logic [N-1:0]   a_mag, b_mag, q, r;
  logic           is_div, neg_q, neg_r, b_zero, sa, sb, go;
  always_comb begin
    sa      = ~bus.op[0] & bus.a[N-1];
    sb      = ~bus.op[0] & bus.b[N-1];
    a_mag   = sa ? -bus.a : bus.a;
    b_mag   = sb ? -bus.b : bus.b;
    go      = bus.start & ~bus.flush;
    state_d = state;
    if (state == IDLE)
      state_d = go ? RUN : IDLE;
    else if (bus.flush)
      state_d = IDLE;
    else if (state == RUN)
      state_d = (cnt == CW'(N-1)) ? FIN : RUN;
    else
      state_d = IDLE;
  end
  // One shared adder: add multiplicand into the upper half, or trial-subtract the divisor
  // from the left-shifted partial remainder (top bit is the borrow).
  always_comb begin
    rem_sh = acc[2*N-1:N-1];
    alu    = is_div ? {1'b0, rem_sh} - {2'b0, opd} : {2'b0, acc[2*N-1:N]} + {2'b0, opd};
    acc_nx = is_div ? (alu[N+1] ? {acc[2*N-2:0], 1'b0} : {alu[N-1:0], acc[N-2:0], 1'b1})
                    : (acc[0] ? {alu[N:0], acc[N-1:1]} : {1'b0, acc[2*N-1:1]});
    prod   = neg_q ? -acc : acc;
    q      = neg_q ? -acc[N-1:0] : acc[N-1:0];
    r      = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
  end
  assign bus.busy = (state != IDLE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opd      <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.div0 <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          is_div <= bus.op[1];
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          b_zero <= (bus.b == '0);
          cnt    <= '0;
          opd    <= bus.op[1] ? b_mag : a_mag;
          acc    <= {{N{1'b0}}, bus.op[1] ? a_mag : b_mag};
        end else begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
        end
      end else if (!bus.flush) begin
        if (state == RUN) begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
        end else begin
          // A zero divisor leaves |a| in the remainder half, so hi comes out as a unchanged.
          bus.done <= 1'b1;
          bus.div0 <= is_div & b_zero;
          bus.hi   <= is_div ? r : prod[2*N-1:N];
          bus.lo   <= is_div ? (b_zero ? '1 : q) : prod[N-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: random and directed checks of md_unit against an arithmetic reference model.
module tb_md_unit;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  md_unit_if #(.N(N)) bus ();
  md_unit #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'b00) begin
      p = 64'(sa * sb);
      return {1'b0, p};
    end
    if (op == 2'b01) begin
      p = {32'b0, a} * {32'b0, b};
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
    if (op == 2'b10) begin
      q = 64'(sa / sb);
      r = 64'(sa % sb);
    end else begin
      q = {32'b0, a / b};
      r = {32'b0, a % b};
    end
    return {1'b0, r[31:0], q[31:0]};
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : -32'($urandom_range(1, 15));
      2: v = 32'h0;
      default: begin
        case ($urandom_range(0, 3))
          0: v = 32'h80000000;
          1: v = 32'hFFFFFFFF;
          2: v = 32'h7FFFFFFF;
          default: v = 32'h1;
        endcase
      end
    endcase
    return v;
  endfunction
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      bc += int'(bus.busy);
    end
    check("done_seen", 64'(bus.done), 64'd1);
  endtask
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    int lat, bc;
    e = model(op, a, b);
    launch(op, a, b);
    check({tag, "_busy0"}, 64'(bus.busy), 64'd1);
    wait_done(lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'(N + 1));
    check({tag, "_busycyc"}, 64'(bc + 1), 64'(N + 1));
    check({tag, "_hilo"}, {bus.hi, bus.lo}, e[63:0]);
    check({tag, "_div0"}, 64'(bus.div0), 64'(e[64]));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {62'b0, bus.done, bus.div0}, 64'd0);
  endtask
  initial begin
    int lat, bc, seen;
    logic [64:0] e;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    #1;
    check("rst_state", {bus.busy, bus.done, bus.div0, 61'b0}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFE, 32'h00000003);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002);
    run_op("divu_7_2", 2'b11, 32'h7, 32'h2);
    run_op("divu_zero", 2'b11, 32'h5, 32'h0);
    run_op("div_zero_s", 2'b10, 32'hFFFFFF00, 32'h0);
    run_op("div_wrap", 2'b10, 32'h80000000, 32'hFFFFFFFF);
    run_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 24; i++)
      run_op($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick(), pick());
    // Second start and an MTHI while busy must both be dropped.
    launch(2'b01, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    wait_done(lat, bc);
    check("busy_ign_lat", 64'(lat + 6), 64'(N + 1));
    check("busy_ign_hilo", {bus.hi, bus.lo}, 64'h00000000_0000000C);
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi_mtlo", {bus.hi, bus.lo}, 64'h12345678_CAFEF00D);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(lat, bc);
    e = model(2'b11, 32'd100, 32'd7);
    check("start_wins", {bus.hi, bus.lo}, e[63:0]);
    launch(2'b11, 32'hFFFF0000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen += int'(bus.done | bus.div0);
    end
    check("flush_nodone", 64'(seen), 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, e[63:0]);
    run_op("after_flush", 2'b00, 32'hFFFFFFFF, 32'h7FFFFFFF);
    launch(2'b00, 32'h12345, 32'h6789);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen += int'(bus.done | bus.busy);
    end
    check("arst_nodone", 64'(seen), 64'd0);
    run_op("post_rst", 2'b10, 32'hFFFFFF85, 32'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
